// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller: register
// address width, controller FSM states and E-stage operand-forward selects.
package pipeline_ctrl_pkg;

    typedef logic [4:0] creg_addr_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        REDIR = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        REGFILE = 2'd0,
        FWD_M   = 2'd1,
        FWD_W   = 2'd2
    } fwd_sel_t;

    // A later stage supplies a source only if it really writes that register; x0 never matches.
    function automatic logic writes_reg(logic valid, logic regwrite, creg_addr_t dst, creg_addr_t src);
        return valid & regwrite & (dst != '0) & (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_fwd_unit.sv
// Combinational forwarding select for one E-stage operand; M stage wins over W.
module fwd_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       m_valid,
    input  logic       m_regwrite,
    input  logic [4:0] m_dst,
    input  logic       w_valid,
    input  logic       w_regwrite,
    input  logic [4:0] w_dst,
    output logic [1:0] sel
);

    always_comb begin
        if (writes_reg(m_valid, m_regwrite, m_dst, src)) begin
            sel = FWD_M;
        end else if (writes_reg(w_valid, w_regwrite, w_dst, src)) begin
            sel = FWD_W;
        end else begin
            sel = REGFILE;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline.
// Optional performance counters are built only when PIPELINE_CTRL_PERF_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_data_ok,
    input  logic        d_valid,
    input  logic        d_use1,
    input  logic        d_use2,
    input  logic [4:0]  d_ra1,
    input  logic [4:0]  d_ra2,
    input  logic        e_valid,
    input  logic        e_memread,
    input  logic        e_regwrite,
    input  logic [4:0]  e_dst,
    input  logic [4:0]  e_ra1,
    input  logic [4:0]  e_ra2,
    input  logic        branch_taken,
    input  logic        m_valid,
    input  logic        m_regwrite,
    input  logic [4:0]  m_dst,
    input  logic        d_req,
    input  logic        d_data_ok,
    input  logic        w_valid,
    input  logic        w_regwrite,
    input  logic [4:0]  w_dst,
    output logic        stall_pc,
    output logic        stall_dreg,
    output logic        stall_ereg,
    output logic        stall_mreg,
    output logic        flush_dreg,
    output logic        flush_ereg,
    output logic        flush_mreg,
    output logic        flush_wreg,
    output logic        i_discard,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flushes
);

    ctrl_state_t state, state_next;
    logic        dwait, iwait, loaduse, redirect;
    logic [1:0]  fwd_a_raw, fwd_b_raw;

    assign dwait = d_req & ~d_data_ok;
    assign iwait = i_req & ~i_data_ok;
    assign loaduse = e_valid & e_memread & (e_dst != 5'd0) & d_valid &
                     ((d_use1 & (d_ra1 == e_dst)) | (d_use2 & (d_ra2 == e_dst)));
    // A taken branch only redirects when no dmem wait is holding E.
    assign redirect = ~dwait & branch_taken & e_valid;

    // NOTE: every output gets a default before the priority chain so no latch is inferred.
    always_comb begin
        stall_pc   = 1'b0;
        stall_dreg = 1'b0;
        stall_ereg = 1'b0;
        stall_mreg = 1'b0;
        flush_dreg = 1'b0;
        flush_ereg = 1'b0;
        flush_mreg = 1'b0;
        flush_wreg = 1'b0;
        i_discard  = 1'b0;

        if (dwait) begin
            stall_pc   = 1'b1;
            stall_dreg = 1'b1;
            stall_ereg = 1'b1;
            stall_mreg = 1'b1;
            flush_wreg = 1'b1;
        end else if (redirect) begin
            flush_dreg = 1'b1;
            flush_ereg = 1'b1;
        end else if (loaduse) begin
            stall_pc   = 1'b1;
            stall_dreg = 1'b1;
            flush_ereg = 1'b1;
        end else if (iwait) begin
            stall_pc   = 1'b1;
            flush_dreg = 1'b1;
        end

        // The stale fetch response of a redirect is dropped until imem answers.
        if (state == REDIR) begin
            i_discard  = 1'b1;
            flush_dreg = 1'b1;
            stall_pc   = 1'b1;
        end

        if (reset) begin
            stall_pc   = 1'b0;
            stall_dreg = 1'b0;
            stall_ereg = 1'b0;
            stall_mreg = 1'b0;
            flush_dreg = 1'b1;
            flush_ereg = 1'b1;
            flush_mreg = 1'b1;
            flush_wreg = 1'b1;
            i_discard  = 1'b0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (dwait) begin
                    state_next = DWAIT;
                end else if (redirect & iwait) begin
                    state_next = REDIR;
                end
            end
            DWAIT:   if (d_data_ok) state_next = RUN;
            REDIR:   if (i_data_ok) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    fwd_unit u_fwd_a (
        .src        (e_ra1),
        .m_valid    (m_valid),
        .m_regwrite (m_regwrite),
        .m_dst      (m_dst),
        .w_valid    (w_valid),
        .w_regwrite (w_regwrite),
        .w_dst      (w_dst),
        .sel        (fwd_a_raw)
    );

    fwd_unit u_fwd_b (
        .src        (e_ra2),
        .m_valid    (m_valid),
        .m_regwrite (m_regwrite),
        .m_dst      (m_dst),
        .w_valid    (w_valid),
        .w_regwrite (w_regwrite),
        .w_dst      (w_dst),
        .sel        (fwd_b_raw)
    );

    assign fwd_a = reset ? REGFILE : fwd_a_raw;
    assign fwd_b = reset ? REGFILE : fwd_b_raw;

`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_pc) stall_cnt <= stall_cnt + 32'd1;
            if (redirect) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_cnt;
    assign perf_flushes      = flush_cnt;
`else
    assign perf_stall_cycles = '0;
    assign perf_flushes      = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus a
// randomized run against a table-driven reference model.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

`ifdef PIPELINE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_req, i_data_ok, d_valid, d_use1, d_use2;
    logic [4:0] d_ra1, d_ra2, e_dst, e_ra1, e_ra2, m_dst, w_dst;
    logic e_valid, e_memread, e_regwrite, branch_taken;
    logic m_valid, m_regwrite, d_req, d_data_ok, w_valid, w_regwrite;
    logic stall_pc, stall_dreg, stall_ereg, stall_mreg;
    logic flush_dreg, flush_ereg, flush_mreg, flush_wreg, i_discard;
    logic [1:0] fwd_a, fwd_b;
    logic [31:0] perf_stall_cycles, perf_flushes;

    int n_cmp = 0;
    int n_bad = 0;

    // {stall_pc,dreg,ereg,mreg, flush_dreg,ereg,mreg,wreg, i_discard}
    logic [8:0] ctl;
    assign ctl = {stall_pc, stall_dreg, stall_ereg, stall_mreg,
                  flush_dreg, flush_ereg, flush_mreg, flush_wreg, i_discard};

    localparam logic [8:0] C_NONE  = 9'b0000_0000_0;
    localparam logic [8:0] C_RESET = 9'b0000_1111_0;
    localparam logic [8:0] C_DWAIT = 9'b1111_0001_0;
    localparam logic [8:0] C_BRANCH = 9'b0000_1100_0;
    localparam logic [8:0] C_LOADUSE = 9'b1100_0100_0;
    localparam logic [8:0] C_IWAIT = 9'b1000_1000_0;
    localparam logic [8:0] C_REDIR = 9'b1000_1000_1;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset), .i_req(i_req), .i_data_ok(i_data_ok),
        .d_valid(d_valid), .d_use1(d_use1), .d_use2(d_use2), .d_ra1(d_ra1), .d_ra2(d_ra2),
        .e_valid(e_valid), .e_memread(e_memread), .e_regwrite(e_regwrite),
        .e_dst(e_dst), .e_ra1(e_ra1), .e_ra2(e_ra2), .branch_taken(branch_taken),
        .m_valid(m_valid), .m_regwrite(m_regwrite), .m_dst(m_dst),
        .d_req(d_req), .d_data_ok(d_data_ok),
        .w_valid(w_valid), .w_regwrite(w_regwrite), .w_dst(w_dst),
        .stall_pc(stall_pc), .stall_dreg(stall_dreg), .stall_ereg(stall_ereg), .stall_mreg(stall_mreg),
        .flush_dreg(flush_dreg), .flush_ereg(flush_ereg), .flush_mreg(flush_mreg), .flush_wreg(flush_wreg),
        .i_discard(i_discard), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .perf_stall_cycles(perf_stall_cycles), .perf_flushes(perf_flushes)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        i_req = 0; i_data_ok = 0; d_valid = 0; d_use1 = 0; d_use2 = 0;
        d_ra1 = 0; d_ra2 = 0; e_valid = 0; e_memread = 0; e_regwrite = 0;
        e_dst = 0; e_ra1 = 0; e_ra2 = 0; branch_taken = 0;
        m_valid = 0; m_regwrite = 0; m_dst = 0; d_req = 0; d_data_ok = 0;
        w_valid = 0; w_regwrite = 0; w_dst = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        d_req = 1; branch_taken = 1; e_valid = 1; i_req = 1;
        e_ra1 = 7; e_ra2 = 3; m_valid = 1; m_regwrite = 1; m_dst = 7;
        w_valid = 1; w_regwrite = 1; w_dst = 3;
        #1;
        n_cmp++; if (ctl !== C_RESET) begin n_bad++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RESET); end
        n_cmp++; if (fwd_a !== 2'd0) begin n_bad++; $display("FAIL reset_fwd_a: got %0d want 0", fwd_a); end
        n_cmp++; if (fwd_b !== 2'd0) begin n_bad++; $display("FAIL reset_fwd_b: got %0d want 0", fwd_b); end
        @(negedge clk);
        n_cmp++; if (perf_stall_cycles !== 32'd0) begin n_bad++; $display("FAIL reset_perf_stall: got %0d want 0", perf_stall_cycles); end
        n_cmp++; if (perf_flushes !== 32'd0) begin n_bad++; $display("FAIL reset_perf_flush: got %0d want 0", perf_flushes); end
        idle();
        reset = 1'b0;
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL reset_release_ctl: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
    endtask

    task automatic test_loaduse();
        do_reset();
        e_valid = 1; e_memread = 1; e_regwrite = 1; e_dst = 5;
        d_valid = 1; d_use1 = 1; d_ra1 = 5;
        #1;
        n_cmp++; if (ctl !== C_LOADUSE) begin n_bad++; $display("FAIL loaduse_ctl: got %b want %b", ctl, C_LOADUSE); end
        @(negedge clk);
        // The bubble now sits in E.
        e_valid = 0; e_memread = 0;
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL loaduse_after: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        e_valid = 1; e_memread = 1; e_dst = 0; d_ra1 = 0;
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL loaduse_x0: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        e_dst = 9; d_use1 = 0; d_ra1 = 9; d_use2 = 1; d_ra2 = 9;
        #1;
        n_cmp++; if (ctl !== C_LOADUSE) begin n_bad++; $display("FAIL loaduse_ra2: got %b want %b", ctl, C_LOADUSE); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_dwait();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d_req = 1; d_data_ok = 0;
            branch_taken = (i == 1); e_valid = (i == 1); i_req = (i == 1);
            #1;
            n_cmp++; if (ctl !== C_DWAIT) begin n_bad++; $display("FAIL dwait_cyc%0d: got %b want %b", i, ctl, C_DWAIT); end
            @(negedge clk);
        end
        branch_taken = 0; e_valid = 0; i_req = 0;
        d_data_ok = 1;
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL dwait_ok: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL dwait_run: got %b want %b", ctl, C_NONE); end
        n_cmp++; if (perf_stall_cycles !== (PERF ? 32'd3 : 32'd0)) begin n_bad++; $display("FAIL dwait_perf_stall: got %0d want %0d", perf_stall_cycles, PERF ? 3 : 0); end
        @(negedge clk);
    endtask

    task automatic test_redirect();
        do_reset();
        i_req = 1; i_data_ok = 0; branch_taken = 1; e_valid = 1;
        #1;
        n_cmp++; if (ctl !== C_BRANCH) begin n_bad++; $display("FAIL redir_branch: got %b want %b", ctl, C_BRANCH); end
        @(negedge clk);
        branch_taken = 0; e_valid = 0;
        #1;
        n_cmp++; if (ctl !== C_REDIR) begin n_bad++; $display("FAIL redir_wait: got %b want %b", ctl, C_REDIR); end
        @(negedge clk);
        i_data_ok = 1;
        #1;
        n_cmp++; if (ctl !== C_REDIR) begin n_bad++; $display("FAIL redir_resp: got %b want %b", ctl, C_REDIR); end
        @(negedge clk);
        i_req = 0; i_data_ok = 0;
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL redir_exit: got %b want %b", ctl, C_NONE); end
        n_cmp++; if (perf_flushes !== (PERF ? 32'd1 : 32'd0)) begin n_bad++; $display("FAIL redir_perf_flush: got %0d want %0d", perf_flushes, PERF ? 1 : 0); end
        n_cmp++; if (perf_stall_cycles !== (PERF ? 32'd2 : 32'd0)) begin n_bad++; $display("FAIL redir_perf_stall: got %0d want %0d", perf_stall_cycles, PERF ? 2 : 0); end
        @(negedge clk);
    endtask

    task automatic test_branch_with_response();
        do_reset();
        i_req = 1; i_data_ok = 1; branch_taken = 1; e_valid = 1;
        #1;
        n_cmp++; if (ctl !== C_BRANCH) begin n_bad++; $display("FAIL brresp_branch: got %b want %b", ctl, C_BRANCH); end
        @(negedge clk);
        branch_taken = 0; e_valid = 0;
        #1;
        n_cmp++; if (ctl !== C_NONE) begin n_bad++; $display("FAIL brresp_no_redir: got %b want %b", ctl, C_NONE); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_forwarding();
        do_reset();
        e_ra1 = 7; e_ra2 = 0;
        m_valid = 1; m_regwrite = 1; m_dst = 7;
        w_valid = 1; w_regwrite = 1; w_dst = 7;
        #1;
        n_cmp++; if (fwd_a !== FWD_M) begin n_bad++; $display("FAIL fwd_m_wins: got %0d want %0d", fwd_a, FWD_M); end
        n_cmp++; if (fwd_b !== REGFILE) begin n_bad++; $display("FAIL fwd_b_none: got %0d want %0d", fwd_b, REGFILE); end
        m_regwrite = 0;
        #1;
        n_cmp++; if (fwd_a !== FWD_W) begin n_bad++; $display("FAIL fwd_w: got %0d want %0d", fwd_a, FWD_W); end
        e_ra2 = 0; m_regwrite = 1; m_dst = 0; w_dst = 0;
        #1;
        n_cmp++; if (fwd_b !== REGFILE) begin n_bad++; $display("FAIL fwd_x0: got %0d want %0d", fwd_b, REGFILE); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_mid_dwait();
        do_reset();
        d_req = 1; d_data_ok = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (ctl !== C_RESET) begin n_bad++; $display("FAIL rst_dwait_ctl: got %b want %b", ctl, C_RESET); end
        n_cmp++; if (perf_stall_cycles !== 32'd0) begin n_bad++; $display("FAIL rst_dwait_perf_stall: got %0d want 0", perf_stall_cycles); end
        n_cmp++; if (perf_flushes !== 32'd0) begin n_bad++; $display("FAIL rst_dwait_perf_flush: got %0d want 0", perf_flushes); end
        @(negedge clk);
        #1;
        n_cmp++; if (ctl !== C_RESET) begin n_bad++; $display("FAIL rst_dwait_held: got %b want %b", ctl, C_RESET); end
        @(negedge clk);
        idle();
        reset = 1'b0;
        // Only RUN may enter REDIR, so a redirect here proves the FSM left DWAIT.
        i_req = 1; branch_taken = 1; e_valid = 1;
        #1;
        n_cmp++; if (ctl !== C_BRANCH) begin n_bad++; $display("FAIL rst_dwait_branch: got %b want %b", ctl, C_BRANCH); end
        @(negedge clk);
        branch_taken = 0; e_valid = 0;
        #1;
        n_cmp++; if (i_discard !== 1'b1) begin n_bad++; $display("FAIL rst_dwait_run_state: got %b want 1", i_discard); end
        @(negedge clk);
        i_data_ok = 1;
        @(negedge clk);
        idle();
    endtask

    // Reference model: penalty rows chosen by the first matching hazard class.
    function automatic logic [1:0] model_fwd(logic [4:0] src);
        logic [4:0] dsts [2];
        logic       wr   [2];
        dsts[0] = m_dst; wr[0] = m_valid & m_regwrite;
        dsts[1] = w_dst; wr[1] = w_valid & w_regwrite;
        for (int s = 0; s < 2; s++)
            if (wr[s] && src != 0 && dsts[s] == src) return 2'(s + 1);
        return 2'd0;
    endfunction

    task automatic test_random();
        int mode;          // 0 running, 1 waiting on dmem, 2 discarding stale fetch
        int exp_stall, exp_flush;
        logic [8:0] penalty [5];
        logic hit [5];
        logic [8:0] exp_ctl;
        logic dw, br;
        penalty[0] = C_DWAIT; penalty[1] = C_BRANCH; penalty[2] = C_LOADUSE;
        penalty[3] = C_IWAIT; penalty[4] = C_NONE;
        do_reset();
        mode = 0; exp_stall = 0; exp_flush = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            i_req = ($urandom_range(0, 2) != 0); i_data_ok = ($urandom_range(0, 1) == 1);
            d_valid = $urandom_range(0, 1); d_use1 = $urandom_range(0, 1); d_use2 = $urandom_range(0, 1);
            d_ra1 = 5'($urandom_range(0, 3)); d_ra2 = 5'($urandom_range(0, 3));
            e_valid = $urandom_range(0, 1); e_memread = $urandom_range(0, 1); e_regwrite = $urandom_range(0, 1);
            e_dst = 5'($urandom_range(0, 3)); e_ra1 = 5'($urandom_range(0, 3)); e_ra2 = 5'($urandom_range(0, 3));
            branch_taken = ($urandom_range(0, 5) == 0);
            m_valid = $urandom_range(0, 1); m_regwrite = $urandom_range(0, 1); m_dst = 5'($urandom_range(0, 3));
            w_valid = $urandom_range(0, 1); w_regwrite = $urandom_range(0, 1); w_dst = 5'($urandom_range(0, 3));
            d_req = ($urandom_range(0, 3) == 0); d_data_ok = $urandom_range(0, 1);

            dw = d_req && !d_data_ok;
            br = branch_taken && e_valid;
            hit[0] = dw;
            hit[1] = br;
            hit[2] = e_valid && e_memread && e_dst != 0 && d_valid &&
                     ((d_use1 && d_ra1 == e_dst) || (d_use2 && d_ra2 == e_dst));
            hit[3] = i_req && !i_data_ok;
            hit[4] = 1'b1;
            exp_ctl = C_NONE;
            for (int k = 0; k < 5; k++) begin
                if (hit[k]) begin exp_ctl = penalty[k]; break; end
            end
            if (mode == 2) exp_ctl = exp_ctl | C_REDIR;

            #1;
            n_cmp++; if (ctl !== exp_ctl) begin n_bad++; $display("FAIL rand_ctl cyc %0d mode %0d: got %b want %b", cyc, mode, ctl, exp_ctl); end
            n_cmp++; if (fwd_a !== model_fwd(e_ra1)) begin n_bad++; $display("FAIL rand_fwd_a cyc %0d: got %0d want %0d", cyc, fwd_a, model_fwd(e_ra1)); end
            n_cmp++; if (fwd_b !== model_fwd(e_ra2)) begin n_bad++; $display("FAIL rand_fwd_b cyc %0d: got %0d want %0d", cyc, fwd_b, model_fwd(e_ra2)); end

            @(posedge clk);
            if (exp_ctl[8]) exp_stall++;
            if (!dw && br) exp_flush++;
            case (mode)
                0: if (dw) mode = 1; else if (br && i_req && !i_data_ok) mode = 2;
                1: if (d_data_ok) mode = 0;
                default: if (i_data_ok) mode = 0;
            endcase
            #1;
            n_cmp++; if (perf_stall_cycles !== (PERF ? 32'(exp_stall) : 32'd0)) begin n_bad++; $display("FAIL rand_perf_stall cyc %0d: got %0d want %0d", cyc, perf_stall_cycles, PERF ? exp_stall : 0); end
            n_cmp++; if (perf_flushes !== (PERF ? 32'(exp_flush) : 32'd0)) begin n_bad++; $display("FAIL rand_perf_flush cyc %0d: got %0d want %0d", cyc, perf_flushes, PERF ? exp_flush : 0); end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_loaduse();
        test_dwait();
        test_redirect();
        test_branch_with_response();
        test_forwarding();
        test_reset_mid_dwait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central hazard and sequencing controller for the five-stage pipeline. Watches the decode, execute and memory stages plus the imem/dmem handshakes, and drives per-register stall/flush controls and E-stage forwarding selects. A small FSM tracks outstanding dmem waits and taken-branch redirects that race an in-flight instruction fetch. Sits at the top level beside the dreg/ereg/mreg/wreg pipeline registers.

## Interface
- No parameters; widths come from `common`/`pipes` (`creg_addr_t` = 5 bits).
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- i_req  in  1  fetch has an imem request outstanding
- i_data_ok  in  1  imem response this cycle
- d_valid, d_use1, d_use2  in  1 each  D-stage instruction valid; reads ra1 / ra2
- d_ra1, d_ra2  in  5 each  D-stage source registers
- e_valid, e_memread, e_regwrite  in  1 each  E-stage status
- e_dst, e_ra1, e_ra2  in  5 each  E-stage destination and sources
- branch_taken  in  1  E-stage taken branch/jump, PC loads target this cycle
- m_valid, m_regwrite  in  1 each; m_dst  in  5
- d_req, d_data_ok  in  1 each  M-stage dmem request / response
- w_valid, w_regwrite  in  1 each; w_dst  in  5
- stall_pc, stall_dreg, stall_ereg, stall_mreg  out  1 each  hold register
- flush_dreg, flush_ereg, flush_mreg, flush_wreg  out  1 each  load bubble
- i_discard  out  1  fetch must drop the current imem response
- fwd_a, fwd_b  out  2 each  E operand source (`fwd_sel_t`)
- perf_stall_cycles, perf_flushes  out  32 each  performance counters

## Operation
- FSM `ctrl_state_t`: RUN, DWAIT, REDIR.
- dwait = d_req & ~d_data_ok. loaduse = e_valid & e_memread & e_dst≠0 & d_valid & ((d_use1 & d_ra1==e_dst) | (d_use2 & d_ra2==e_dst)). iwait = i_req & ~i_data_ok.
- Priority, first match wins:
  1. dwait: stall_pc/dreg/ereg/mreg = 1, flush_wreg = 1; branch_taken ignored (branch held in E).
  2. branch_taken & e_valid: flush_dreg = flush_ereg = 1. If iwait, next state REDIR.
  3. loaduse: stall_pc = stall_dreg = 1, flush_ereg = 1.
  4. iwait: stall_pc = 1, flush_dreg = 1.
  5. Otherwise all stall/flush = 0.
- Transitions: RUN→DWAIT on dwait; DWAIT→RUN on d_data_ok. RUN→REDIR per rule 2. REDIR→RUN on i_data_ok.
- In REDIR: i_discard = 1, flush_dreg = 1, stall_pc = 1. Rule 1 still applies on top; REDIR exit is independent of dmem state.
- Forwarding per operand: M if m_valid & m_regwrite & m_dst≠0 & m_dst==src (2'd1); else W with the same test on w_* (2'd2); else REGFILE (2'd0). M wins over W.
- Register x0 never triggers hazard or forwarding.

## Timing
- Stall, flush, i_discard and fwd outputs are combinational from inputs and registered state: zero-cycle latency.
- State and counters update on posedge clk.
- Load-use costs exactly one bubble. Each dmem wait cycle costs one cycle. The stale fetch response in REDIR costs the cycles until i_data_ok.
- Simultaneous branch_taken and i_data_ok in RUN: response flushed via flush_dreg; no REDIR entry.
- Reset (async, any state): state = RUN, counters = 0. While reset is high: stall_* = 0, flush_* = 1, i_discard = 0, fwd_* = REGFILE.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined:
  - perf_stall_cycles increments, wrapping, in every cycle with stall_pc = 1.
  - perf_flushes increments on every cycle where rule 2 fires.
- Undefined: both ports tied to 0 and no counter flops are built.

## Structure
- `pipes`: `ctrl_state_t` enum and `fwd_sel_t` enum (REGFILE=0, FWD_M=1, FWD_W=2).
- `common`: `creg_addr_t`.
- One sub-module, `fwd_unit`: purely combinational, instantiated twice (operands a and b).

## Test plan
- E: load with e_dst=5, D reads ra1=5 → one cycle with stall_pc = stall_dreg = flush_ereg = 1, then RUN with no stall.
- Same case with e_dst=0 → no stall.
- d_req=1, d_data_ok low for 3 cycles → DWAIT; stall_pc/dreg/ereg/mreg and flush_wreg high for 3 cycles; RUN after d_data_ok.
- branch_taken while i_req=1, i_data_ok=0 → REDIR; i_discard = 1 until i_data_ok arrives 2 cycles later; back in RUN next cycle; perf_flushes = 1 (macro defined).
- E src ra1=7 with m_dst=7 and w_dst=7, both regwrite → fwd_a = FWD_M; clear m_regwrite → FWD_W.
- Reset asserted mid-DWAIT → state RUN and counters 0 immediately; flush_* = 1 while reset is held.
